// File: rtl/param_acc_cpu_pkg.sv
// Shared opcode and controller-state encodings for the parametrised accumulator CPU.
// Instruction word layout is {opcode[3:0], operand[DATA_W-1:0]}.
package param_acc_cpu_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_LDX  = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_ADDX = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5;
  localparam logic [3:0] OP_AND  = 4'h6;
  localparam logic [3:0] OP_OR   = 4'h7;
  localparam logic [3:0] OP_XOR  = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_JZ   = 4'hA;
  localparam logic [3:0] OP_JC   = 4'hB;
  localparam logic [3:0] OP_OUT  = 4'hC;
  localparam logic [3:0] OP_SHL  = 4'hD;
  localparam logic [3:0] OP_HLT  = 4'hE;
  localparam logic [3:0] OP_RSV  = 4'hF;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_IDLE = 2'd1,
    ST_RUN  = 2'd2,
    ST_HALT = 2'd3
  } state_t;

endpackage

// File: rtl/acc_alu.sv
// Combinational ALU: computes the new accumulator value and flags for one opcode.
// carry/overflow/zero are only meaningful when acc_we is high; otherwise flags hold.
module acc_alu
  import param_acc_cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] operand,
  input  logic [3:0]        opcode,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              overflow,
  output logic              zero,
  output logic              acc_we
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  assign sum  = {1'b0, acc} + {1'b0, operand};
  // Bit DATA_W of the extended difference is the unsigned borrow.
  assign diff = {1'b0, acc} - {1'b0, operand};

  always_comb begin
    result   = acc;
    carry    = 1'b0;
    overflow = 1'b0;
    acc_we   = 1'b0;
    case (opcode)
      OP_LDI, OP_LDX: begin
        result = operand;
        acc_we = 1'b1;
      end
      OP_ADD, OP_ADDX: begin
        result   = sum[DATA_W-1:0];
        carry    = sum[DATA_W];
        overflow = (acc[DATA_W-1] == operand[DATA_W-1]) && (sum[DATA_W-1] != acc[DATA_W-1]);
        acc_we   = 1'b1;
      end
      OP_SUB: begin
        result   = diff[DATA_W-1:0];
        carry    = diff[DATA_W];
        overflow = (acc[DATA_W-1] != operand[DATA_W-1]) && (diff[DATA_W-1] != acc[DATA_W-1]);
        acc_we   = 1'b1;
      end
      OP_AND: begin
        result = acc & operand;
        acc_we = 1'b1;
      end
      OP_OR: begin
        result = acc | operand;
        acc_we = 1'b1;
      end
      OP_XOR: begin
        result = acc ^ operand;
        acc_we = 1'b1;
      end
      OP_SHL: begin
        result = {acc[DATA_W-2:0], 1'b0};
        carry  = acc[DATA_W-1];
        acc_we = 1'b1;
      end
      OP_NOP, OP_RSV, OP_JMP, OP_JZ, OP_JC, OP_OUT, OP_HLT: ;
      default: ;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/param_acc_cpu.sv
// Accumulator CPU top: program-load handshake, program store, pc and LOAD/IDLE/RUN/HALT control.
// One instruction per cycle in RUN; fetch is combinational from the store at pc.
module param_acc_cpu
  import param_acc_cpu_pkg::*;
#(
  parameter  int DATA_W     = 8,
  parameter  int PROG_DEPTH = 16,
  localparam int PC_W       = $clog2(PROG_DEPTH),
  localparam int INSTR_W    = 4 + DATA_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               prog_valid,
  output logic               prog_ready,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic               prog_last,
  input  logic               start,
  input  logic [DATA_W-1:0]  ext_in,
  output logic [DATA_W-1:0]  acc_out,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_valid,
  output logic               carry,
  output logic               zero,
  output logic               overflow,
  output logic [PC_W-1:0]    pc_out,
  output logic [1:0]         state_out
);

  state_t              state_reg, state_next;
  logic [PC_W-1:0]     pc_reg, pc_next, laddr_reg;
  logic [DATA_W-1:0]   acc_reg, out_data_reg;
  logic                out_valid_reg, carry_reg, zero_reg, overflow_reg;
  logic [INSTR_W-1:0]  mem [PROG_DEPTH];

  logic [INSTR_W-1:0]  instr;
  logic [3:0]          opcode;
  logic [DATA_W-1:0]   imm, alu_operand, alu_result;
  logic                alu_carry, alu_overflow, alu_zero, alu_we;
  logic                load_fire, run_start;

  assign instr       = mem[pc_reg];
  assign opcode      = instr[INSTR_W-1 -: 4];
  assign imm         = instr[DATA_W-1:0];
  assign alu_operand = (opcode == OP_LDX || opcode == OP_ADDX) ? ext_in : imm;
  assign load_fire   = (state_reg == ST_LOAD) && prog_valid;
  assign run_start   = ((state_reg == ST_IDLE) || (state_reg == ST_HALT)) && start;

  acc_alu #(.DATA_W(DATA_W)) u_alu (
    .acc      (acc_reg),
    .operand  (alu_operand),
    .opcode   (opcode),
    .result   (alu_result),
    .carry    (alu_carry),
    .overflow (alu_overflow),
    .zero     (alu_zero),
    .acc_we   (alu_we)
  );

  // Store is wiped to NOP on reset so a short reload never runs stale code.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PROG_DEPTH; i++) mem[i] <= '0;
    end else if (load_fire) begin
      mem[laddr_reg] <= prog_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_LOAD;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_LOAD: if (load_fire && (prog_last || laddr_reg == PC_W'(PROG_DEPTH - 1))) state_next = ST_IDLE;
      ST_IDLE, ST_HALT: if (start) state_next = ST_RUN;
      ST_RUN: if (opcode == OP_HLT) state_next = ST_HALT;
      default: state_next = ST_LOAD;
    endcase
  end

  // Conditional jumps test the flags as they stood before this instruction.
  always_comb begin
    pc_next = pc_reg + PC_W'(1);
    case (opcode)
      OP_JMP: pc_next = imm[PC_W-1:0];
      OP_JZ:  if (zero_reg)  pc_next = imm[PC_W-1:0];
      OP_JC:  if (carry_reg) pc_next = imm[PC_W-1:0];
      OP_HLT: pc_next = pc_reg;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg        <= '0;
      laddr_reg     <= '0;
      acc_reg       <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      carry_reg     <= 1'b0;
      overflow_reg  <= 1'b0;
      zero_reg      <= 1'b1;
    end else begin
      out_valid_reg <= 1'b0;
      if (load_fire) laddr_reg <= laddr_reg + PC_W'(1);
      if (run_start) begin
        pc_reg       <= '0;
        acc_reg      <= '0;
        carry_reg    <= 1'b0;
        overflow_reg <= 1'b0;
        zero_reg     <= 1'b1;
      end else if (state_reg == ST_RUN) begin
        pc_reg <= pc_next;
        if (alu_we) begin
          acc_reg      <= alu_result;
          carry_reg    <= alu_carry;
          overflow_reg <= alu_overflow;
          zero_reg     <= alu_zero;
        end
        if (opcode == OP_OUT) begin
          out_data_reg  <= acc_reg;
          out_valid_reg <= 1'b1;
        end
      end
    end
  end

  assign prog_ready = (state_reg == ST_LOAD);
  assign acc_out    = acc_reg;
  assign out_data   = out_data_reg;
  assign out_valid  = out_valid_reg;
  assign carry      = carry_reg;
  assign zero       = zero_reg;
  assign overflow   = overflow_reg;
  assign pc_out     = pc_reg;
  assign state_out  = state_reg;

endmodule

// File: tb/tb_param_acc_cpu.sv
// Bench for param_acc_cpu: integer-arithmetic reference model checked every cycle,
// plus directed programs with hand-computed literal expectations.
module tb_param_acc_cpu;

  localparam int DATA_W  = 8;
  localparam int DEPTH   = 16;
  localparam int PC_W    = $clog2(DEPTH);
  localparam int INSTR_W = 4 + DATA_W;
  localparam int DMAX    = 1 << DATA_W;
  localparam int HALF    = DMAX / 2;

  typedef logic [INSTR_W-1:0] word_q_t[$];

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               prog_valid = 1'b0;
  logic               prog_ready;
  logic [INSTR_W-1:0] prog_data = '0;
  logic               prog_last = 1'b0;
  logic               start = 1'b0;
  logic [DATA_W-1:0]  ext_in = '0;
  logic [DATA_W-1:0]  acc_out, out_data;
  logic               out_valid, carry, zero, overflow;
  logic [PC_W-1:0]    pc_out;
  logic [1:0]         state_out;

  int n_checks = 0;
  int n_errors = 0;

  param_acc_cpu #(.DATA_W(DATA_W), .PROG_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .prog_valid (prog_valid),
    .prog_ready (prog_ready),
    .prog_data  (prog_data),
    .prog_last  (prog_last),
    .start      (start),
    .ext_in     (ext_in),
    .acc_out    (acc_out),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .carry      (carry),
    .zero       (zero),
    .overflow   (overflow),
    .pc_out     (pc_out),
    .state_out  (state_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (architectural, integer arithmetic) ----------------
  int m_prog[DEPTH];
  int m_state, m_pc, m_laddr, m_acc, m_out, m_oval, m_c, m_v, m_z;
  bit m_ok = 1'b0;
  int x_op, x_imm, x_ext, x_b, x_res, x_s, x_pc;
  bit x_wr;

  function automatic int sx(input int a);
    return (a >= HALF) ? a - DMAX : a;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_state = 0; m_pc = 0; m_laddr = 0; m_acc = 0; m_out = 0; m_oval = 0;
      m_c = 0; m_v = 0; m_z = 1; m_ok = 1'b1;
      foreach (m_prog[i]) m_prog[i] = 0;
    end else begin
      m_oval = 0;
      if (m_state == 0) begin
        if (prog_valid) begin
          m_prog[m_laddr] = int'(prog_data);
          if (prog_last || m_laddr == DEPTH - 1) m_state = 1;
          m_laddr = (m_laddr + 1) % DEPTH;
        end
      end else if (m_state == 1 || m_state == 3) begin
        if (start) begin
          m_state = 2; m_pc = 0; m_acc = 0; m_c = 0; m_v = 0; m_z = 1;
        end
      end else begin
        x_op  = m_prog[m_pc] / DMAX;
        x_imm = m_prog[m_pc] % DMAX;
        x_ext = int'(ext_in);
        x_pc  = (m_pc + 1) % DEPTH;
        x_wr  = 1'b1;
        x_res = m_acc;
        case (x_op)
          1, 2: begin x_res = (x_op == 1) ? x_imm : x_ext; m_c = 0; m_v = 0; end
          3, 4: begin
            x_b   = (x_op == 3) ? x_imm : x_ext;
            x_res = m_acc + x_b;
            m_c   = (x_res >= DMAX) ? 1 : 0;
            x_s   = sx(m_acc) + sx(x_b);
            m_v   = (x_s >= HALF || x_s < -HALF) ? 1 : 0;
            x_res = x_res % DMAX;
          end
          5: begin
            m_c   = (m_acc < x_imm) ? 1 : 0;
            x_s   = sx(m_acc) - sx(x_imm);
            m_v   = (x_s >= HALF || x_s < -HALF) ? 1 : 0;
            x_res = (m_acc - x_imm + DMAX) % DMAX;
          end
          6: begin x_res = m_acc & x_imm; m_c = 0; m_v = 0; end
          7: begin x_res = m_acc | x_imm; m_c = 0; m_v = 0; end
          8: begin x_res = m_acc ^ x_imm; m_c = 0; m_v = 0; end
          9: begin x_pc = x_imm % DEPTH; x_wr = 1'b0; end
          10: begin if (m_z != 0) x_pc = x_imm % DEPTH; x_wr = 1'b0; end
          11: begin if (m_c != 0) x_pc = x_imm % DEPTH; x_wr = 1'b0; end
          12: begin m_out = m_acc; m_oval = 1; x_wr = 1'b0; end
          13: begin m_c = (m_acc >= HALF) ? 1 : 0; x_res = (m_acc * 2) % DMAX; m_v = 0; end
          14: begin m_state = 3; x_pc = m_pc; x_wr = 1'b0; end
          default: x_wr = 1'b0;
        endcase
        if (x_wr) begin
          m_acc = x_res;
          m_z   = (x_res == 0) ? 1 : 0;
        end
        m_pc = x_pc;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_ok) begin
      chk("state",     32'(state_out),  m_state);
      chk("pc",        32'(pc_out),     m_pc);
      chk("acc",       32'(acc_out),    m_acc);
      chk("carry",     32'(carry),      m_c);
      chk("overflow",  32'(overflow),   m_v);
      chk("zero",      32'(zero),       m_z);
      chk("out_valid", 32'(out_valid),  m_oval);
      chk("out_data",  32'(out_data),   m_out);
      chk("prog_ready", 32'(prog_ready), (m_state == 0) ? 1 : 0);
      if (out_valid) $display("out pulse data=%02h", out_data);
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [INSTR_W-1:0] ins(input int op, input int imm);
    return INSTR_W'(op * DMAX + imm);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; prog_valid = 1'b0; prog_last = 1'b0; start = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic load_prog(input word_q_t words, input bit mark_last);
    for (int i = 0; i < words.size(); i++) begin
      if (i % 2 == 1) begin
        prog_valid = 1'b0;
        tick(1);
      end
      prog_valid = 1'b1;
      prog_data  = words[i];
      prog_last  = (mark_last && i == words.size() - 1) ? 1'b1 : 1'b0;
      $display("load word %0d = %03h last=%0b", i, words[i], prog_last);
      tick(1);
    end
    prog_valid = 1'b0;
    prog_last  = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    word_q_t prog;

    // reset values and a 3-word program
    tick(1);
    do_reset();
    chk("rst_state", 32'(state_out), 0);
    chk("rst_ready", 32'(prog_ready), 1);
    chk("rst_zero",  32'(zero), 1);
    chk("rst_acc",   32'(acc_out), 0);
    prog = '{ins(1, 8'h05), ins(3, 8'h03), ins(12, 0)};
    load_prog(prog, 1'b1);
    chk("t1_idle",  32'(state_out), 1);
    chk("t1_ready", 32'(prog_ready), 0);
    do_start();
    chk("t1_run", 32'(state_out), 2);
    tick(2);
    chk("t1_acc", 32'(acc_out), 8);
    chk("t1_nopulse", 32'(out_valid), 0);
    tick(1);
    chk("t1_oval",  32'(out_valid), 1);
    chk("t1_odata", 32'(out_data), 8'h08);
    chk("t1_carry", 32'(carry), 0);
    chk("t1_ovf",   32'(overflow), 0);
    tick(1);
    chk("t1_oval_end", 32'(out_valid), 0);

    // carry/zero from wrap-around add, then JC and JZ taken
    do_reset();
    prog = '{ins(1, 8'hFF), ins(3, 8'h01), ins(11, 5), 0, 0, ins(10, 8), 0, 0, ins(14, 0)};
    load_prog(prog, 1'b1);
    do_start();
    tick(2);
    chk("t2_acc",   32'(acc_out), 0);
    chk("t2_carry", 32'(carry), 1);
    chk("t2_zero",  32'(zero), 1);
    tick(1);
    chk("t2_jc_pc", 32'(pc_out), 5);
    tick(1);
    chk("t2_jz_pc", 32'(pc_out), 8);
    tick(1);
    chk("t2_halt", 32'(state_out), 3);
    tick(2);
    chk("t2_pc_frozen", 32'(pc_out), 8);

    // signed overflow and borrow
    do_reset();
    prog = '{ins(1, 8'h7F), ins(3, 8'h01), ins(1, 8'h00), ins(5, 8'h01), ins(14, 0)};
    load_prog(prog, 1'b1);
    do_start();
    tick(2);
    chk("t3_acc80", 32'(acc_out), 8'h80);
    chk("t3_ovf",   32'(overflow), 1);
    chk("t3_carry", 32'(carry), 0);
    tick(1);
    chk("t3_ovf_clr", 32'(overflow), 0);
    tick(1);
    chk("t3_accFF",  32'(acc_out), 8'hFF);
    chk("t3_borrow", 32'(carry), 1);

    // full-store load without prog_last, pc wrap, start ignored in LOAD and RUN
    do_reset();
    prog = {};
    for (int i = 0; i < DEPTH; i++) prog.push_back(ins(3, 1));
    start = 1'b1;
    load_prog(prog, 1'b0);
    start = 1'b0;
    chk("t4_idle",  32'(state_out), 1);
    chk("t4_ready", 32'(prog_ready), 0);
    prog_valid = 1'b1; prog_data = ins(14, 0);
    tick(1);
    prog_valid = 1'b0;
    do_start();
    tick(DEPTH);
    chk("t4_wrap_pc", 32'(pc_out), 0);
    chk("t4_acc16",   32'(acc_out), 16);
    tick(1);
    chk("t4_pc1", 32'(pc_out), 1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("t4_start_ign_pc",  32'(pc_out), 2);
    chk("t4_start_ign_acc", 32'(acc_out), 18);

    // LDX, back-to-back OUT, HLT, restart from HALT
    do_reset();
    ext_in = 8'hA5;
    prog = '{ins(2, 0), ins(12, 0), ins(12, 0), ins(14, 0)};
    load_prog(prog, 1'b1);
    do_start();
    tick(1);
    chk("t5_ldx", 32'(acc_out), 8'hA5);
    tick(1);
    chk("t5_oval1", 32'(out_valid), 1);
    chk("t5_odata", 32'(out_data), 8'hA5);
    tick(1);
    chk("t5_oval2", 32'(out_valid), 1);
    tick(1);
    chk("t5_oval_end", 32'(out_valid), 0);
    chk("t5_halt",     32'(state_out), 3);
    tick(2);
    chk("t5_pc_frozen", 32'(pc_out), 3);
    do_start();
    chk("t5_restart_state", 32'(state_out), 2);
    chk("t5_restart_pc",    32'(pc_out), 0);
    chk("t5_restart_acc",   32'(acc_out), 0);

    // shift and logic ops, then reset mid-run
    do_reset();
    ext_in = 8'h80;
    prog = '{ins(1, 8'hC3), ins(13, 0), ins(6, 8'h0F), ins(7, 8'hF0), ins(8, 8'hF6),
             ins(4, 0), ins(5, 8'h81), ins(14, 0)};
    load_prog(prog, 1'b1);
    do_start();
    tick(2);
    chk("t6_shl_acc",   32'(acc_out), 8'h86);
    chk("t6_shl_carry", 32'(carry), 1);
    tick(3);
    chk("t6_xor_acc",  32'(acc_out), 0);
    chk("t6_xor_zero", 32'(zero), 1);
    tick(2);
    chk("t6_sub_acc",   32'(acc_out), 8'hFF);
    chk("t6_sub_carry", 32'(carry), 1);
    tick(1);
    do_start();
    tick(3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("t6_rst_state", 32'(state_out), 0);
    chk("t6_rst_pc",    32'(pc_out), 0);
    chk("t6_rst_acc",   32'(acc_out), 0);
    chk("t6_rst_zero",  32'(zero), 1);
    chk("t6_rst_ready", 32'(prog_ready), 1);

    // reset during a stalled load; store must read back as NOP
    prog_valid = 1'b1; prog_data = ins(1, 8'hAA);
    tick(1);
    prog_valid = 1'b0;
    tick(1);
    prog_valid = 1'b1; prog_data = ins(1, 8'hBB); rst = 1'b1;
    tick(1);
    rst = 1'b0; prog_valid = 1'b0;
    chk("t7_rst_state", 32'(state_out), 0);
    prog = '{ins(0, 0)};
    load_prog(prog, 1'b1);
    chk("t7_idle", 32'(state_out), 1);
    do_start();
    tick(20);
    chk("t7_nop_acc",   32'(acc_out), 0);
    chk("t7_nop_state", 32'(state_out), 2);

    tick(1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/param_acc_cpu.md
Name: param_acc_cpu

Overview:
Parametrised accumulator CPU: the next generation of the team's 4-bit TinyTapeout CPU, generalised to DATA_W-bit data and a PROG_DEPTH-word program store. Adds features the 4-bit core lacks:
- a runtime program-load handshake in place of a fixed ROM;
- conditional jumps;
- an output port with a valid strobe;
- a LOAD/IDLE/RUN/HALT controller.

It sits below the top-level pin wrapper, which maps ext_in, out_data and the flags onto the ui/uo/uio pins.

Parameters:
DATA_W, 8, accumulator/operand/ALU width (min 4)
PROG_DEPTH, 16, program words (power of 2, min 4)
PC_W, $clog2(PROG_DEPTH), derived; not overridable
INSTR_W, 4+DATA_W, derived; instr = {opcode[3:0], operand[DATA_W-1:0]}

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
prog_valid  in  1  program word offered
prog_ready  out  1  store accepts word (LOAD state only)
prog_data  in  INSTR_W  program word
prog_last  in  1  marks final word of load
start  in  1  begin execution at pc 0 (IDLE/HALT only)
ext_in  in  DATA_W  external operand
acc_out  out  DATA_W  accumulator
out_data  out  DATA_W  output register
out_valid  out  1  1-cycle pulse when out_data written
carry  out  1  carry/borrow flag
zero  out  1  accumulator==0 flag
overflow  out  1  signed overflow flag
pc_out  out  PC_W  program counter
state_out  out  2  LOAD=0, IDLE=1, RUN=2, HALT=3

Behaviour:
- Reset values:
  - state=LOAD; pc, load address, acc, out_data and out_valid all 0.
  - carry=0, overflow=0, zero=1.
  - All program words cleared to 0 (NOP).
- Reset mid-load or mid-run aborts immediately; the same reset values apply.
- LOAD:
  - prog_ready=1. On prog_valid&prog_ready, mem[laddr]<=prog_data and laddr++.
  - Go to IDLE on an accepted word with prog_last=1, or on acceptance at laddr==PROG_DEPTH-1 (store full, no wrap).
  - Unwritten words stay NOP. The store is reloadable only via rst.
- IDLE/HALT:
  - prog_ready=0. On start: pc<=0, acc<=0, flags cleared (zero=1), go to RUN.
  - start is ignored in LOAD and RUN.
- RUN executes one instruction per cycle: combinational fetch of mem[pc], results registered at the clock edge.
- Default pc <= pc+1, wrapping PROG_DEPTH-1 -> 0.
- Opcodes (imm = operand):
  - 0 NOP
  - 1 LDI acc=imm
  - 2 LDX acc=ext_in
  - 3 ADD acc+=imm
  - 4 ADDX acc+=ext_in
  - 5 SUB acc-=imm
  - 6 AND imm
  - 7 OR imm
  - 8 XOR imm
  - 9 JMP pc=imm[PC_W-1:0]
  - A JZ (jump if zero)
  - B JC (jump if carry)
  - C OUT out_data<=acc, out_valid=1 next cycle
  - D SHL acc<<1, carry=msb out
  - E HLT to HALT, pc holds
  - F reserved = NOP
- Arithmetic:
  - DATA_W+1-bit add; carry = bit DATA_W.
  - SUB: carry=1 on borrow (acc<imm unsigned).
  - Overflow = signed two's-complement overflow, for ADD/ADDX/SUB only.
- Flag updates:
  - Logic ops and LDI/LDX clear carry and overflow.
  - zero is updated on every acc write.
  - Jumps, OUT, NOP and HLT leave all flags unchanged.
  - JZ/JC test the flags as registered before the jump executes.
- out_valid is high exactly 1 cycle per OUT. Back-to-back OUTs give consecutive pulses.
- Only rst leaves HALT toward LOAD.

Decomposition:
- Shared package param_acc_cpu_pkg holds:
  - opcode localparams OP_NOP..OP_HLT;
  - state encoding ST_LOAD/IDLE/RUN/HALT.
- One sub-module, acc_alu (combinational):
  - in: acc, operand, opcode;
  - out: result, carry, overflow, zero, and a write-enable for acc.
- The controller, program store and pc stay in the top.

Test Plan:
- Reset, then load 3 words {LDI 0x05, ADD 0x03, OUT} with prog_last on word 3, start -> state RUN; out_data=0x08, out_valid pulse on cycle 4; carry=0, overflow=0.
- LDI 0xFF, ADD 0x01 -> acc=0x00, carry=1, zero=1; then JC 5 -> pc=5; JZ taken on the next cycle.
- LDI 0x7F, ADD 0x01 -> acc=0x80, overflow=1, carry=0; LDI 0x00, SUB 0x01 -> acc=0xFF, carry=1 (borrow).
- Load all 16 words with prog_last never asserted -> IDLE after word 16, prog_ready=0. A program without HLT wraps pc 15 -> 0.
- LDX with ext_in=0xA5, OUT, HLT -> out_data=0xA5, state HALT, pc frozen; start -> pc=0, acc=0, RUN again.
- Assert rst mid-RUN and during prog_valid stalls -> all reset values, memory = NOP, state LOAD next cycle.
